// File: rtl/des_dec_key_sched_if.sv
// Handshake bundle between the DES decrypt key schedule and its consumer.
// master drives start/key/subkey_ready; slave is the key schedule itself.
interface des_dec_key_sched_if;
  logic        start;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        weak_key;

  modport master (
    output start, key, subkey_ready,
    input  subkey, subkey_valid, round,
    input  busy, done, weak_key
  );

  modport slave (
    input  start, key, subkey_ready,
    output subkey, subkey_valid, round,
    output busy, done, weak_key
  );
endinterface

// File: rtl/des_dec_key_sched.sv
// Iterative DES decrypt key schedule: K16 down to K1, one per handshake.
// Optional weak-key flag built only when DES_WEAK_KEY_DETECT_EN is defined.
module des_dec_key_sched #(
  parameter int unsigned ALLOW_RESTART = 0
) (
  input logic                 clk,
  input logic                 rst,
  des_dec_key_sched_if.slave  bus
);

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // FIPS bit n (1 = MSB) lives at vector index WIDTH-n
  function automatic logic [55:0] pc1(
    input logic [63:0] k
  );
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(
    input logic [55:0] cd
  );
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2[i]];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotr(
    input logic [27:0] x,
    input logic        two
  );
    return two ? {x[1:0], x[27:2]}
               : {x[0], x[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  step_q, step_d;
  logic        done_q, done_d;

  logic [55:0] cd0;
  logic [27:0] c0, d0;
  logic        run, fire, last;
  logic        load, two;

  assign cd0  = pc1(bus.key);
  assign c0   = cd0[55:28];
  assign d0   = cd0[27:0];
  assign run  = (state_q == RUN);
  assign fire = run & bus.subkey_ready;
  assign last = (step_q == 4'd15);
  assign load = bus.start &
                (!run || ALLOW_RESTART != 0);
  // single-bit rotates before K15, K8 and K1
  assign two  = !(step_q == 4'd0 ||
                  step_q == 4'd7 ||
                  step_q == 4'd14);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    done_d  = 1'b0;
    unique case (1'b1)
      load: begin
        state_d = RUN;
        c_d     = c0;
        d_d     = d0;
        step_d  = 4'd0;
      end
      (!load && fire && last): begin
        state_d = IDLE;
        step_d  = 4'd0;
        done_d  = 1'b1;
      end
      (!load && fire && !last): begin
        c_d    = rotr(c_q, two);
        d_d    = rotr(d_q, two);
        step_d = step_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bus.subkey       = pc2({c_q, d_q});
  assign bus.subkey_valid = run;
  assign bus.busy         = run;
  assign bus.round        = run ? 4'd0 - step_q
                                : 4'd0;
  assign bus.done         = done_q;

`ifdef DES_WEAK_KEY_DETECT_EN
  logic weak_q, weak_d;

  assign weak_d = load ? ((&c0 | ~|c0) &
                          (&d0 | ~|d0))
                       : weak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weak_q <= 1'b0;
    end else begin
      weak_q <= weak_d;
    end
  end

  assign bus.weak_key = weak_q;
`else
  assign bus.weak_key = 1'b0;
`endif

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Scoreboard bench for the DES decrypt key schedule.
// Instance a: ALLOW_RESTART=0, instance b: ALLOW_RESTART=1.
module tb_des_dec_key_sched;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] WKEY = 64'h0101010101010101;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   a_done_cnt = 0;
  int   b_done_cnt = 0;
  logic [51:0] q [$];
  logic        stall_q = 1'b0;
  logic [47:0] stall_key;
  logic [3:0]  stall_rnd;
  logic        exp_weak;

  des_dec_key_sched_if a_if ();
  des_dec_key_sched_if b_if ();

  des_dec_key_sched #(.ALLOW_RESTART(0)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  des_dec_key_sched #(.ALLOW_RESTART(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Forward (encrypt-direction) schedule: Kn after n left rotations
  function automatic logic [47:0] ref_key(input logic [63:0] k,
                                          input int n);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] r;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-PC1[i]];
      d[27-i] = k[64-PC1[i+28]];
    end
    for (int s = 1; s <= n; s++) begin
      if (s == 1 || s == 2 || s == 9 || s == 16) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [63:0] k);
    for (int n = 16; n >= 1; n--) q.push_back({ref_key(k, n), 4'(n)});
  endtask

  task automatic launch(input logic [63:0] k);
    a_if.start = 1'b1;
    a_if.key   = k;
    push_model(k);
    cyc();
    a_if.start = 1'b0;
    a_if.key   = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_if.done) break;
    end
    chk(tag, a_if.done, 1'b1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_if.subkey_valid && a_if.round == r) break;
    end
    chk("wait_round", a_if.round, r);
  endtask

  always @(negedge clk) begin
    logic [51:0] e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && a_if.subkey_valid) begin
        chk("stall_key", a_if.subkey, stall_key);
        chk("stall_rnd", a_if.round, stall_rnd);
      end
      stall_q   = a_if.subkey_valid && !a_if.subkey_ready;
      stall_key = a_if.subkey;
      stall_rnd = a_if.round;
      if (a_if.done) a_done_cnt++;
      if (b_if.done) b_done_cnt++;
      if (a_if.subkey_valid && a_if.subkey_ready) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("sb_key", a_if.subkey, e[51:4]);
          chk("sb_rnd", a_if.round, e[3:0]);
        end
      end
    end
  end

  initial begin
    int vcnt;
    int hold;
    int d0;
`ifdef DES_WEAK_KEY_DETECT_EN
    exp_weak = 1'b1;
`else
    exp_weak = 1'b0;
`endif
    a_if.start = 1'b0;
    a_if.key = '0;
    a_if.subkey_ready = 1'b1;
    b_if.start = 1'b0;
    b_if.key = '0;
    b_if.subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", a_if.subkey_valid, 1'b0);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_round", a_if.round, 4'd0);
    chk("rst_subkey", a_if.subkey, 48'd0);
    chk("rst_done", a_if.done, 1'b0);
    chk("rst_weak", a_if.weak_key, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: back-to-back sequence
    d0 = a_done_cnt;
    launch(KEY);
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t1_k16", a_if.subkey, 48'hCB3D8B0E17F5);
        chk("t1_r16", a_if.round, 4'd0);
        chk("t1_busy", a_if.busy, 1'b1);
        chk("t1_weak", a_if.weak_key, 1'b0);
      end
      if (a_if.subkey_valid) vcnt++;
    end
    chk("t1_vcnt", vcnt, 16);
    @(negedge clk);
    chk("t1_done", a_if.done, 1'b1);
    chk("t1_end_valid", a_if.subkey_valid, 1'b0);
    chk("t1_end_busy", a_if.busy, 1'b0);
    chk("t1_end_round", a_if.round, 4'd0);
    chk("t1_k1_hold", a_if.subkey, 48'h1B02EFFC7072);
    @(negedge clk);
    chk("t1_done_pulse", a_if.done, 1'b0);
    chk("t1_done_cnt", a_done_cnt - d0, 1);
    cyc();

    // 2: ready toggling with a 5-cycle hold at K8
    d0 = a_done_cnt;
    launch(KEY);
    hold = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_if.subkey_valid && a_if.round == 4'd8 && hold < 5) begin
        a_if.subkey_ready = 1'b0;
        hold++;
      end else begin
        a_if.subkey_ready = !a_if.subkey_ready;
      end
      cyc();
      if (a_if.done) break;
    end
    chk("t2_done", a_if.done, 1'b1);
    chk("t2_hold", hold, 5);
    chk("t2_drain", q.size(), 0);
    a_if.subkey_ready = 1'b1;
    cyc();
    chk("t2_done_cnt", a_done_cnt - d0, 1);

    // 3: weak key
    launch(WKEY);
    @(negedge clk);
    chk("t3_weak", a_if.weak_key, exp_weak);
    chk("t3_k16", a_if.subkey, 48'd0);
    wait_done("t3_done");
    cyc();

    // 4: reset mid-sequence at K10
    launch(KEY);
    wait_round(4'd10);
    #2 rst = 1'b1;
    #1;
    chk("t4_valid", a_if.subkey_valid, 1'b0);
    chk("t4_busy", a_if.busy, 1'b0);
    chk("t4_round", a_if.round, 4'd0);
    q.delete();
    repeat (2) cyc();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_if.subkey_valid) vcnt++;
    end
    chk("t4_idle", vcnt, 0);
    cyc();
    launch(KEY2);
    @(negedge clk);
    chk("t4_new_k16", a_if.subkey, ref_key(KEY2, 16));
    wait_done("t4_done");
    cyc();

    // 5a: start at K12 ignored without restart
    d0 = a_done_cnt;
    launch(KEY);
    wait_round(4'd13);
    cyc();
    a_if.start = 1'b1;
    a_if.key = KEY2;
    cyc();
    a_if.start = 1'b0;
    wait_done("t5a_done");
    chk("t5a_k1", a_if.subkey, 48'h1B02EFFC7072);
    cyc();
    chk("t5a_done_cnt", a_done_cnt - d0, 1);

    // 5b: start at K12 restarts with restart enabled
    d0 = b_done_cnt;
    b_if.start = 1'b1;
    b_if.key = KEY;
    cyc();
    b_if.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_if.subkey_valid && b_if.round == 4'd13) break;
    end
    chk("t5b_r13", b_if.round, 4'd13);
    cyc();
    b_if.start = 1'b1;
    b_if.key = KEY2;
    cyc();
    b_if.start = 1'b0;
    b_if.key = KEY;
    @(negedge clk);
    chk("t5b_k16", b_if.subkey, ref_key(KEY2, 16));
    chk("t5b_r16", b_if.round, 4'd0);
    chk("t5b_valid", b_if.subkey_valid, 1'b1);
    chk("t5b_nodone", b_if.done, 1'b0);
    @(negedge clk);
    chk("t5b_k15", b_if.subkey, ref_key(KEY2, 15));
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_if.done) break;
    end
    chk("t5b_done", b_if.done, 1'b1);
    chk("t5b_k1", b_if.subkey, ref_key(KEY2, 1));
    cyc();
    chk("t5b_done_cnt", b_done_cnt - d0, 1);

    // 6: start in the done cycle
    launch(KEY);
    wait_round(4'd1);
    cyc();
    chk("t6_done", a_if.done, 1'b1);
    launch(KEY2);
    @(negedge clk);
    chk("t6_valid", a_if.subkey_valid, 1'b1);
    chk("t6_r16", a_if.round, 4'd0);
    wait_done("t6_fin");
    cyc();
    chk("sb_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
